// File: rtl/atm_pkg.sv
// Shared encodings and default widths for the ATM balance arbiter slice.
package atm_pkg;

  localparam int unsigned DEF_N_TERM = 4;
  localparam int unsigned DEF_ACCT_W = 3;
  localparam int unsigned DEF_BAL_W  = 64;
  localparam int unsigned DEF_AMT_W  = 32;

  typedef enum logic {
    OP_DEPOSITO = 1'b0,
    OP_RETIRO   = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE
  } state_e;

  typedef enum logic [1:0] {
    RES_OK,
    RES_NSF,
    RES_OVF
  } res_e;

endpackage

// File: rtl/atm_balance_arbiter_rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last winner.
module rr_arbiter #(
  parameter int unsigned N_TERM = 4,
  parameter int unsigned IW     = (N_TERM > 1) ? $clog2(N_TERM) : 1
) (
  input  logic [N_TERM-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic [N_TERM-1:0] grant,
  output logic [IW-1:0]     idx,
  output logic              valid
);

  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= N_TERM; k++) begin
      cand = IW'((32'(ptr) + k) % N_TERM);
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/atm_balance_arbiter.sv
// Round-robin shared read-modify-write on an account balance store for N_TERM terminals.
module atm_balance_arbiter
  import atm_pkg::*;
#(
  parameter int unsigned N_TERM = DEF_N_TERM,
  parameter int unsigned ACCT_W = DEF_ACCT_W,
  parameter int unsigned BAL_W  = DEF_BAL_W,
  parameter int unsigned AMT_W  = DEF_AMT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_TERM-1:0]          req,
  input  logic [N_TERM-1:0]          req_op,
  input  logic [N_TERM*ACCT_W-1:0]   req_acct,
  input  logic [N_TERM*AMT_W-1:0]    req_amt,
  input  logic                       init_stb,
  input  logic [ACCT_W-1:0]          init_acct,
  input  logic [BAL_W-1:0]           init_val,
  output logic [N_TERM-1:0]          gnt,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(N_TERM)-1:0]  done_term,
  output logic                       balance_actualizado,
  output logic                       fondos_insuficientes,
  output logic                       overflow,
  output logic [BAL_W-1:0]           balance_out
);

  localparam int unsigned IW     = $clog2(N_TERM);
  localparam int unsigned N_ACCT = 2 ** ACCT_W;

  state_e state, state_d;

  logic [IW-1:0]     ptr;
  logic [IW-1:0]     win_idx;
  logic [N_TERM-1:0] win_gnt;
  logic              win_valid;
  logic              accept;
  logic              init_we;

  logic [ACCT_W-1:0] acct_arr [N_TERM];
  logic [AMT_W-1:0]  amt_arr  [N_TERM];

  op_e               op_q;
  logic [IW-1:0]     term_q;
  logic [ACCT_W-1:0] acct_q;
  logic [AMT_W-1:0]  amt_q;
  logic [BAL_W-1:0]  bal_q;
  logic [BAL_W-1:0]  res_q;
  res_e              kind_q;

  logic [BAL_W-1:0]  amt_ext;
  logic [BAL_W:0]    sum;
  logic [BAL_W-1:0]  new_bal;
  res_e              kind_d;

  logic [BAL_W-1:0]  mem [N_ACCT];

  always_comb begin
    for (int unsigned i = 0; i < N_TERM; i++) begin
      acct_arr[i] = req_acct[i*ACCT_W +: ACCT_W];
      amt_arr[i]  = req_amt[i*AMT_W +: AMT_W];
    end
  end

  rr_arbiter #(
    .N_TERM (N_TERM),
    .IW     (IW)
  ) u_rr (
    .req   (req),
    .ptr   (ptr),
    .grant (win_gnt),
    .idx   (win_idx),
    .valid (win_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // init_stb outranks a pending request; the request is simply seen again next cycle
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    init_we = 1'b0;
    case (state)
      S_IDLE: begin
        if (init_stb) begin
          init_we = 1'b1;
        end else if (win_valid) begin
          accept  = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    amt_ext = BAL_W'(amt_q);
    sum     = {1'b0, bal_q} + {1'b0, amt_ext};
    new_bal = bal_q;
    kind_d  = RES_OK;
    if (op_q == OP_DEPOSITO) begin
      if (sum[BAL_W]) kind_d  = RES_OVF;
      else            new_bal = sum[BAL_W-1:0];
    end else begin
      if (amt_ext > bal_q) kind_d  = RES_NSF;
      else                 new_bal = bal_q - amt_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr                  <= IW'(N_TERM - 1);
      gnt                  <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      done_term            <= '0;
      balance_actualizado  <= 1'b0;
      fondos_insuficientes <= 1'b0;
      overflow             <= 1'b0;
      balance_out          <= '0;
      op_q                 <= OP_DEPOSITO;
      term_q               <= '0;
      acct_q               <= '0;
      amt_q                <= '0;
      bal_q                <= '0;
      res_q                <= '0;
      kind_q               <= RES_OK;
      for (int unsigned a = 0; a < N_ACCT; a++) mem[a] <= '0;
    end else begin
      gnt                  <= accept ? win_gnt : '0;
      busy                 <= (state_d != S_IDLE);
      done                 <= 1'b0;
      balance_actualizado  <= 1'b0;
      fondos_insuficientes <= 1'b0;
      overflow             <= 1'b0;
      if (accept) begin
        ptr    <= win_idx;
        term_q <= win_idx;
        op_q   <= op_e'(req_op[win_idx]);
        acct_q <= acct_arr[win_idx];
        amt_q  <= amt_arr[win_idx];
      end
      if (init_we) mem[init_acct] <= init_val;
      if (state == S_READ) bal_q <= mem[acct_q];
      if (state == S_EXEC) begin
        res_q  <= new_bal;
        kind_q <= kind_d;
      end
      if (state == S_WRITE) begin
        if (kind_q == RES_OK) mem[acct_q] <= res_q;
        done                 <= 1'b1;
        done_term            <= term_q;
        balance_out          <= res_q;
        balance_actualizado  <= (kind_q == RES_OK);
        fondos_insuficientes <= (kind_q == RES_NSF);
        overflow             <= (kind_q == RES_OVF);
      end
    end
  end

endmodule

// File: tb/tb_atm_balance_arbiter.sv
// Directed plus randomized bench for atm_balance_arbiter against a sequential ledger model.
module tb_atm_balance_arbiter;

  localparam int N  = 4;
  localparam int AW = 3;
  localparam int BW = 64;
  localparam int MW = 32;
  localparam logic [63:0] MAXB = 64'hFFFF_FFFF_FFFF_FFFF;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    req_op;
  logic [N*AW-1:0] req_acct;
  logic [N*MW-1:0] req_amt;
  logic            init_stb;
  logic [AW-1:0]   init_acct;
  logic [BW-1:0]   init_val;
  logic [N-1:0]    gnt;
  logic            busy;
  logic            done;
  logic [1:0]      done_term;
  logic            balance_actualizado;
  logic            fondos_insuficientes;
  logic            overflow;
  logic [BW-1:0]   balance_out;

  atm_balance_arbiter #(
    .N_TERM (N),
    .ACCT_W (AW),
    .BAL_W  (BW),
    .AMT_W  (MW)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .req                  (req),
    .req_op               (req_op),
    .req_acct             (req_acct),
    .req_amt              (req_amt),
    .init_stb             (init_stb),
    .init_acct            (init_acct),
    .init_val             (init_val),
    .gnt                  (gnt),
    .busy                 (busy),
    .done                 (done),
    .done_term            (done_term),
    .balance_actualizado  (balance_actualizado),
    .fondos_insuficientes (fondos_insuficientes),
    .overflow             (overflow),
    .balance_out          (balance_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] mb [8];
  bit          t_op   [N];
  int          t_acct [N];
  logic [31:0] t_amt  [N];
  int          bptr;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Ledger rules: deposit must fit in 64 bits, withdrawal may not exceed balance
  task automatic model(input int t, output logic [2:0] k, output logic [63:0] res);
    logic [63:0] b;
    logic [63:0] a;
    b = mb[t_acct[t]];
    a = {32'h0, t_amt[t]};
    res = b;
    if (!t_op[t]) begin
      if (a > MAXB - b) k = 3'b001;
      else begin k = 3'b100; res = b + a; end
    end else begin
      if (a > b) k = 3'b010;
      else begin k = 3'b100; res = b - a; end
    end
    mb[t_acct[t]] = res;
  endtask

  task automatic set_term(input int t, input bit op, input int acct, input logic [31:0] amt);
    t_op[t] = op; t_acct[t] = acct; t_amt[t] = amt;
    req_op[t] = op;
    req_acct[t*AW +: AW] = acct[AW-1:0];
    req_amt[t*MW +: MW] = amt;
  endtask

  task automatic do_init(input int a, input logic [63:0] v);
    init_acct = a[AW-1:0];
    init_val  = v;
    init_stb  = 1'b1;
    @(negedge clk);
    init_stb  = 1'b0;
    mb[a] = v;
  endtask

  task automatic wait_batch(input bit init_in_read);
    int q_t[$];
    int q_c[$];
    int last_g;
    int c;
    int w;
    int t;
    int gc;
    bit pulse;
    bit inject;
    logic [2:0]  ek;
    logic [63:0] eb;
    last_g = -1; c = 0; pulse = 1'b0; inject = init_in_read;
    while ((req != 0 || q_t.size() != 0) && c < 200) begin
      @(negedge clk);
      c++;
      if (pulse) begin init_stb = 1'b0; pulse = 1'b0; end
      if (done) begin
        if (q_t.size() == 0) chk("spurious_done", 65'd1, 65'd0);
        else begin
          t  = q_t.pop_front();
          gc = q_c.pop_front();
          model(t, ek, eb);
          chk("done_term", 65'(done_term), 65'(t));
          chk("done_latency", 65'(c - gc), 65'd3);
          chk("flags", 65'({balance_actualizado, fondos_insuficientes, overflow}), 65'(ek));
          chk("balance_out", 65'(balance_out), 65'(eb));
          chk("busy_at_done", 65'(busy), 65'd0);
        end
      end
      if (gnt != 0) begin
        w = rr_pick(req, bptr);
        chk("gnt", 65'(gnt), (w < 0) ? 65'd0 : 65'(1 << w));
        chk("gnt_latency", 65'(c - ((last_g < 0) ? 0 : last_g)), (last_g < 0) ? 65'd1 : 65'd4);
        chk("busy_at_gnt", 65'(busy), 65'd1);
        if (w >= 0) begin
          bptr = w;
          q_t.push_back(w);
          q_c.push_back(c);
        end
        last_g = c;
        req = req & ~gnt;
        if (inject) begin
          init_acct = 3'd6; init_val = 64'd999; init_stb = 1'b1;
          pulse = 1'b1; inject = 1'b0;
        end
      end
    end
    init_stb = 1'b0;
    if (c >= 200) chk("batch_timeout", 65'd1, 65'd0);
  endtask

  initial begin
    int n;
    int a;
    logic [N-1:0] m;
    rst = 1'b1; req = '0; req_op = '0; req_acct = '0; req_amt = '0;
    init_stb = 1'b0; init_acct = '0; init_val = '0;
    for (int i = 0; i < 8; i++) mb[i] = '0;
    bptr = N - 1;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 65'(gnt), 65'd0);
    chk("rst_busy", 65'(busy), 65'd0);
    chk("rst_done", 65'(done), 65'd0);
    chk("rst_flags", 65'({balance_actualizado, fondos_insuficientes, overflow}), 65'd0);
    chk("rst_balance_out", 65'(balance_out), 65'd0);
    chk("rst_done_term", 65'(done_term), 65'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: deposit
    do_init(2, 64'd1000);
    set_term(1, 1'b0, 2, 32'd250); req = 4'b0010; wait_batch(1'b0);
    // 2: exact withdrawal then insufficient funds
    set_term(0, 1'b1, 2, 32'd1250); req = 4'b0001; wait_batch(1'b0);
    set_term(0, 1'b1, 2, 32'd1); req = 4'b0001; wait_batch(1'b0);
    // amount 0 from term 3 leaves the pointer at 3
    set_term(3, 1'b0, 3, 32'd0); req = 4'b1000; wait_batch(1'b0);
    // 3: all four at once
    do_init(1, 64'd10);
    set_term(0, 1'b0, 1, 32'd100);
    set_term(1, 1'b1, 1, 32'd30);
    set_term(2, 1'b0, 3, 32'd5);
    set_term(3, 1'b1, 1, 32'd81);
    req = 4'b1111; wait_batch(1'b0);
    // 4: overflow boundary
    do_init(0, 64'hFFFF_FFFF_FFFF_FFF6);
    set_term(2, 1'b0, 0, 32'd10); req = 4'b0100; wait_batch(1'b0);
    set_term(2, 1'b0, 0, 32'd9); req = 4'b0100; wait_batch(1'b0);
    // 5: init collides with req, then init during READ
    set_term(1, 1'b0, 5, 32'd7);
    init_acct = 3'd5; init_val = 64'd500; init_stb = 1'b1; req = 4'b0010;
    @(negedge clk);
    chk("init_defers_gnt", 65'(gnt), 65'd0);
    init_stb = 1'b0; mb[5] = 64'd500;
    wait_batch(1'b0);
    set_term(3, 1'b0, 6, 32'd11); req = 4'b1000; wait_batch(1'b1);
    set_term(0, 1'b0, 6, 32'd0); req = 4'b0001; wait_batch(1'b0);
    // 6: reset while in EXEC
    do_init(4, 64'd77);
    set_term(2, 1'b0, 4, 32'd3); req = 4'b0100;
    n = 0;
    while (gnt == 0 && n < 10) begin @(negedge clk); n++; end
    chk("abort_gnt_seen", 65'(gnt), 65'b0100);
    req = '0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 1) rst = 1'b0;
      chk("abort_no_done", 65'(done), 65'd0);
    end
    for (int i = 0; i < 8; i++) mb[i] = '0;
    bptr = N - 1;
    for (int t = 0; t < N; t++) set_term(t, 1'b0, t, 32'd0);
    req = 4'b1111; wait_batch(1'b0);
    for (int t = 0; t < N; t++) set_term(t, 1'b0, t + 4, 32'd0);
    req = 4'b1111; wait_batch(1'b0);

    // randomized batches
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        a = int'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) do_init(a, {32'hFFFF_FFFF, 32'($urandom)});
        else do_init(a, {32'h0, 32'($urandom)});
      end
      m = 4'($urandom_range(1, 15));
      for (int t = 0; t < N; t++) begin
        if (m[t]) begin
          a = int'($urandom_range(0, 7));
          case ($urandom_range(0, 3))
            0:       set_term(t, 1'($urandom_range(0, 1)), a, 32'd0);
            1:       set_term(t, 1'($urandom_range(0, 1)), a, 32'($urandom_range(1, 500)));
            2:       set_term(t, 1'($urandom_range(0, 1)), a, mb[a][31:0]);
            default: set_term(t, 1'($urandom_range(0, 1)), a, 32'($urandom));
          endcase
        end
      end
      req = m;
      wait_batch(1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
